// File: rtl/mux_rr_arbiter.sv
// mux_rr_arbiter: round-robin arbiter and select controller for a shared
// N:1 data mux. One owner at a time; the owner keeps the grant while its
// req stays high, then one IDLE turnaround cycle precedes the next grant.
// Optional feature macro: ARB_TIMEOUT_EN (forced revoke after MAX_HOLD
// OWN cycles when another requester is waiting).
module mux_rr_arbiter #(
  parameter int N_REQ    = 4,
  parameter int DATA_W   = 8,
  parameter int MAX_HOLD = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic [N_REQ-1:0]           req,
  input  logic [N_REQ*DATA_W-1:0]    data_in,
  output logic [N_REQ-1:0]           gnt,
  output logic [$clog2(N_REQ)-1:0]   sel,
  output logic [DATA_W-1:0]          data_out,
  output logic                       out_valid,
  output logic                       busy
);

  localparam int SEL_W = $clog2(N_REQ);
  localparam logic [N_REQ-1:0] GNT_LSB = {{(N_REQ-1){1'b0}}, 1'b1};
  localparam logic [SEL_W-1:0] LAST_RST = SEL_W'(N_REQ - 1);

  if (N_REQ < 2 || MAX_HOLD < 1) begin : g_bad_params
    $error("mux_rr_arbiter: N_REQ must be >= 2 and MAX_HOLD >= 1");
  end

  typedef enum logic {
    IDLE = 1'b0,
    OWN  = 1'b1
  } state_t;

  state_t            state, state_d;
  logic [SEL_W-1:0]  last_ptr;
  logic [SEL_W-1:0]  pick_idx;
  logic [SEL_W-1:0]  cand;
  logic              pick_found;
  logic              take_grant;
  logic              release_own;
  logic              timeout_hit;
  logic [DATA_W-1:0] lane [N_REQ];
  logic [DATA_W-1:0] sel_data;

  for (genvar i = 0; i < N_REQ; i++) begin : g_lane
    assign lane[i] = data_in[i*DATA_W +: DATA_W];
  end

  assign sel_data = lane[sel];
  assign busy     = (state == OWN);

  // Round-robin pick: first set req bit scanning upward from last_ptr+1, wrapping.
  always_comb begin
    pick_found = 1'b0;
    pick_idx   = '0;
    cand       = '0;
    for (int unsigned k = 1; k <= N_REQ; k++) begin
      cand = SEL_W'((32'(last_ptr) + k) % N_REQ);
      if (!pick_found && req[cand]) begin
        pick_found = 1'b1;
        pick_idx   = cand;
      end
    end
  end

`ifdef ARB_TIMEOUT_EN
  localparam int HC_W = $clog2(MAX_HOLD + 1);
  localparam logic [HC_W-1:0] HOLD_MAX = HC_W'(MAX_HOLD);

  logic [HC_W-1:0] hold_cnt;

  // Hold counter: zero outside OWN (so it starts at 0 on entry), saturates at MAX_HOLD.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hold_cnt <= '0;
    end else if (state != OWN) begin
      hold_cnt <= '0;
    end else if (hold_cnt != HOLD_MAX) begin
      hold_cnt <= hold_cnt + HC_W'(1);
    end
  end

  assign timeout_hit = (hold_cnt == HOLD_MAX) && (|(req & ~gnt));
`else
  assign timeout_hit = 1'b0;
`endif

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_d;
    end
  end

  // Next-state decode and grant/release strobes.
  always_comb begin
    state_d     = state;
    take_grant  = 1'b0;
    release_own = 1'b0;
    case (state)
      IDLE: begin
        if (pick_found) begin
          state_d    = OWN;
          take_grant = 1'b1;
        end
      end
      OWN: begin
        if (!req[sel] || timeout_hit) begin
          state_d     = IDLE;
          release_own = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Grant, select, rotation pointer and registered mux output.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      gnt       <= '0;
      sel       <= '0;
      last_ptr  <= LAST_RST;
      data_out  <= '0;
      out_valid <= 1'b0;
    end else if (take_grant) begin
      gnt <= GNT_LSB << pick_idx;
      sel <= pick_idx;
    end else if (release_own) begin
      // data_out keeps the last owner word; sel is left pointing at it.
      gnt       <= '0;
      last_ptr  <= sel;
      out_valid <= 1'b0;
    end else if (state == OWN) begin
      data_out  <= sel_data;
      out_valid <= 1'b1;
    end
  end

endmodule

// File: tb/tb_mux_rr_arbiter.sv
// Directed bench for mux_rr_arbiter: expected data words are queued when a
// lane is driven and popped when the registered output should carry them.
module tb_mux_rr_arbiter;

  logic        clk;
  logic        rst_n;
  logic [3:0]  req;
  logic [31:0] data_in;
  logic [3:0]  gnt;
  logic [1:0]  sel;
  logic [7:0]  data_out;
  logic        out_valid;
  logic        busy;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0] exp_q [$];

  mux_rr_arbiter #(.N_REQ(4), .DATA_W(8), .MAX_HOLD(4)) dut (
    .clk(clk), .rst_n(rst_n), .req(req), .data_in(data_in),
    .gnt(gnt), .sel(sel), .data_out(data_out),
    .out_valid(out_valid), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drive_lanes(input int owner);
    logic [7:0] v;
    v = 8'($urandom_range(0, 255));
    for (int i = 0; i < 4; i++)
      data_in[i*8 +: 8] = (i == owner) ? v : (v ^ 8'(8'h11 * (i + 1)));
    exp_q.push_back(v);
  endtask

  task automatic pop_check(input string tag);
    logic [7:0] e;
    if (exp_q.size() == 0) begin
      n_assert++;
      n_fail++;
      $error("FAIL %s: observed empty scoreboard expected queued word", tag);
    end else begin
      e = exp_q.pop_front();
      check(tag, 32'(data_out), 32'(e));
    end
  endtask

  initial begin
    int order [5] = '{0, 1, 2, 3, 0};
    logic [7:0] last_word;

    rst_n = 1'b0; req = '0; data_in = '0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_gnt", 32'(gnt), 32'h0);
    check("rst_sel", 32'(sel), 32'h0);
    check("rst_data", 32'(data_out), 32'h0);
    check("rst_valid", 32'(out_valid), 32'h0);
    check("rst_busy", 32'(busy), 32'h0);
    rst_n = 1'b1;
    tick();

    // Single requester, grant latency 1, data latency 2.
    req = 4'b0001;
    data_in = 32'h1234_56A5;
    exp_q.push_back(8'hA5);
    tick();
    check("t2_gnt", 32'(gnt), 32'h1);
    check("t2_sel", 32'(sel), 32'h0);
    check("t2_busy", 32'(busy), 32'h1);
    check("t2_valid0", 32'(out_valid), 32'h0);
    tick();
    check("t2_valid1", 32'(out_valid), 32'h1);
    pop_check("t2_data");
    req = 4'b0000;
    tick();
    check("t2_rel_gnt", 32'(gnt), 32'h0);
    check("t2_rel_valid", 32'(out_valid), 32'h0);
    check("t2_hold_data", 32'(data_out), 32'hA5);
    check("t2_hold_sel", 32'(sel), 32'h0);

    // Async reset while owning clears outputs without an edge.
    req = 4'b0001;
    tick();
    tick();
    check("t1_pre_busy", 32'(busy), 32'h1);
    #3;
    rst_n = 1'b0;
    #1;
    check("t1_gnt", 32'(gnt), 32'h0);
    check("t1_busy", 32'(busy), 32'h0);
    check("t1_valid", 32'(out_valid), 32'h0);
    check("t1_data", 32'(data_out), 32'h0);
    req = 4'b0000;
    #1;
    rst_n = 1'b1;
    tick();

    // All requesting: rotation 0,1,2,3,0 with one idle cycle between grants.
    req = 4'b1111;
    tick();
    for (int k = 0; k < 5; k++) begin
      check("t3_gnt", 32'(gnt), 32'(4'b0001 << order[k]));
      check("t3_sel", 32'(sel), 32'(order[k]));
      for (int c = 0; c < 3; c++) begin
        drive_lanes(order[k]);
        last_word = exp_q[exp_q.size() - 1];
        tick();
        check("t3_valid", 32'(out_valid), 32'h1);
        pop_check("t3_data");
      end
      req[order[k]] = 1'b0;
      tick();
      check("t3_gap_gnt", 32'(gnt), 32'h0);
      check("t3_gap_busy", 32'(busy), 32'h0);
      check("t3_gap_data", 32'(data_out), 32'(last_word));
      req[order[k]] = 1'b1;
      tick();
    end
    check("t3_last_gnt", 32'(gnt), 32'h2);
    req = 4'b0000;
    tick();

    // Owner 2 drops with 1 and 3 pending: wrap order picks 3; non-owners ignored.
    req = 4'b0100;
    tick();
    check("t4_own2", 32'(gnt), 32'h4);
    req = 4'b1010;
    tick();
    check("t4_gap", 32'(gnt), 32'h0);
    tick();
    check("t4_gnt3", 32'(gnt), 32'h8);
    check("t4_sel3", 32'(sel), 32'h3);
    for (int c = 0; c < 3; c++) begin
      tick();
      check("t4_hold3", 32'(gnt), 32'h8);
    end
    req = 4'b0000;
    tick();

    // Long hold with a competing requester.
    req = 4'b0001;
    tick();
    req = 4'b0011;
`ifdef ARB_TIMEOUT_EN
    for (int c = 0; c < 5; c++) begin
      check("t5_hold0", 32'(gnt), 32'h1);
      tick();
    end
    check("t5_revoke", 32'(gnt), 32'h0);
    tick();
    check("t5_gnt1", 32'(gnt), 32'h2);
`else
    for (int c = 0; c < 100; c++) begin
      check("t5_hold0", 32'(gnt), 32'h1);
      tick();
    end
`endif
    req = 4'b0000;
    tick();
    check("t5_idle", 32'(gnt), 32'h0);

    // Data tracks the selected lane with one cycle of lag only.
    req = 4'b0100;
    tick();
    check("t6_gnt", 32'(gnt), 32'h4);
    for (int c = 0; c < 8; c++) begin
      drive_lanes(2);
      tick();
      check("t6_valid", 32'(out_valid), 32'h1);
      pop_check("t6_data");
    end
    req = 4'b0000;
    tick();
    check("t6_end_gnt", 32'(gnt), 32'h0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
